// File: rtl/mem_access_unit_if.sv
// Data-memory bus bundle: one request channel (valid/ready) and one response channel (rvalid, no backpressure).
// Master is the load/store engine; slave is the memory or interconnect.
interface mem_access_unit_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   logic                     bus_valid;
   logic                     bus_ready;
   logic                     bus_we;
   logic [ADDRESS_WIDTH-1:0] bus_addr;
   logic [DATA_WIDTH-1:0]    bus_wdata;
   logic [3:0]               bus_wstrb;
   logic                     bus_rvalid;
   logic [DATA_WIDTH-1:0]    bus_rdata;
   logic                     bus_rerr;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ready, bus_rvalid, bus_rdata, bus_rerr
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ready, bus_rvalid, bus_rdata, bus_rerr
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: 3 stall cycles best case (IDLE, REQ, RESP), result in DONE; illegal/misaligned resolve in 1.
// Waits on bus_ready in REQ and bus_rvalid in RESP; every wait cycle extends stall_m.
module mem_access_unit #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_read_m,
   input  logic                     mem_write_m,
   input  logic [2:0]               funct3_m,
   input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
   input  logic [DATA_WIDTH-1:0]    write_data_m,
   output logic [DATA_WIDTH-1:0]    read_data_m,
   output logic                     stall_m,
   output logic                     misaligned_m,
   output logic                     fault_m,
   mem_access_unit_if.master        bus
);
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]               f3_q, f3_d;
   logic                     we_q, we_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [3:0]               wstrb_q, wstrb_d;
   logic                     mis_q, mis_d;
   logic                     flt_q, flt_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

   logic                     op, illegal, misal;
   logic [3:0]               strb_new;
   logic [DATA_WIDTH-1:0]    wdata_new, load_ext;
   logic [7:0]               ld_byte;
   logic [15:0]              ld_half;

   // Decode of the incoming request; only meaningful while IDLE.
   always_comb begin
      op      = mem_read_m | mem_write_m;
      illegal = (funct3_m == 3'b011) || (funct3_m == 3'b110) || (funct3_m == 3'b111)
                || (mem_read_m && mem_write_m);
      case (funct3_m[1:0])
         2'b01:   misal = alu_result_m[0];
         2'b10:   misal = |alu_result_m[1:0];
         default: misal = 1'b0;
      endcase
      case (funct3_m[1:0])
         2'b00: begin
            strb_new  = 4'b0001 << alu_result_m[1:0];
            wdata_new = {4{write_data_m[7:0]}};
         end
         2'b01: begin
            strb_new  = 4'b0011 << alu_result_m[1:0];
            wdata_new = {2{write_data_m[15:0]}};
         end
         default: begin
            strb_new  = 4'b1111;
            wdata_new = write_data_m;
         end
      endcase
   end

   // Lane select and extension of the returned word.
   always_comb begin
      case (addr_q[1:0])
         2'b00:   ld_byte = bus.bus_rdata[7:0];
         2'b01:   ld_byte = bus.bus_rdata[15:8];
         2'b10:   ld_byte = bus.bus_rdata[23:16];
         default: ld_byte = bus.bus_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_ext = {24'd0, ld_byte};
         3'b101:  load_ext = {16'd0, ld_half};
         default: load_ext = bus.bus_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      f3_d         = f3_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      mis_d        = mis_q;
      flt_d        = flt_q;
      rdata_d      = rdata_q;
      stall_m      = 1'b0;
      misaligned_m = 1'b0;
      fault_m      = 1'b0;
      bus.bus_valid = 1'b0;
      case (state_q)
         IDLE: begin
            stall_m = op;
            if (op) begin
               addr_d  = alu_result_m;
               f3_d    = funct3_m;
               we_d    = mem_write_m;
               wstrb_d = mem_write_m ? strb_new : 4'b0000;
               wdata_d = mem_write_m ? wdata_new : '0;
               flt_d   = illegal;
               mis_d   = !illegal && misal;
               if (illegal || misal) begin
                  rdata_d = '0;
                  state_d = DONE;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            bus.bus_valid = 1'b1;
            stall_m       = 1'b1;
            if (bus.bus_ready) state_d = RESP;
         end
         RESP: begin
            stall_m = 1'b1;
            if (bus.bus_rvalid) begin
               flt_d   = bus.bus_rerr;
               rdata_d = (we_q || bus.bus_rerr) ? '0 : load_ext;
               state_d = DONE;
            end
         end
         default: begin
            misaligned_m = mis_q;
            fault_m      = flt_q;
            mis_d        = 1'b0;
            flt_d        = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         mis_q   <= 1'b0;
         flt_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         mis_q   <= mis_d;
         flt_q   <= flt_d;
         rdata_q <= rdata_d;
      end
   end

   assign read_data_m   = rdata_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_wstrb = wstrb_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: the bench plays the bus slave cycle by cycle.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_m, mem_write_m;
   logic [2:0]  funct3_m;
   logic [31:0] alu_result_m, write_data_m, read_data_m;
   logic        stall_m, misaligned_m, fault_m;
   int          total = 0;
   int          bad   = 0;
   int          stall_cnt;
   logic [31:0] o_addr, o_wdata, o_rd;
   logic [3:0]  o_strb;
   logic        o_we;

   mem_access_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bif ();

   mem_access_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read_m   (mem_read_m),
      .mem_write_m  (mem_write_m),
      .funct3_m     (funct3_m),
      .alu_result_m (alu_result_m),
      .write_data_m (write_data_m),
      .read_data_m  (read_data_m),
      .stall_m      (stall_m),
      .misaligned_m (misaligned_m),
      .fault_m      (fault_m),
      .bus          (bif.master)
   );

   always #5 clk = ~clk;

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Best-case access: ready and rvalid held high, so IDLE, REQ, RESP, DONE in four cycles.
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         output logic [31:0] oa, output logic [31:0] ow, output logic [31:0] ord,
                         output logic [3:0] os, output logic owe);
      next();
      mem_read_m = rd; mem_write_m = wr; funct3_m = f3; alu_result_m = a; write_data_m = wd;
      bif.bus_ready = 1'b1; bif.bus_rvalid = 1'b1; bif.bus_rerr = 1'b0; bif.bus_rdata = rdat;
      #1;
      chk("c0_stall", stall_m, 1); chk("c0_valid", bif.bus_valid, 0);
      next();
      chk("c1_stall", stall_m, 1); chk("c1_valid", bif.bus_valid, 1);
      oa = bif.bus_addr; ow = bif.bus_wdata; os = bif.bus_wstrb; owe = bif.bus_we;
      next();
      chk("c2_stall", stall_m, 1); chk("c2_valid", bif.bus_valid, 0);
      next();
      chk("c3_stall", stall_m, 0);
      ord = read_data_m;
   endtask

   initial begin
      rst = 1'b1; mem_read_m = 0; mem_write_m = 0; funct3_m = 3'b010;
      alu_result_m = 0; write_data_m = 0;
      bif.bus_ready = 0; bif.bus_rvalid = 0; bif.bus_rdata = 0; bif.bus_rerr = 0;
      next(); next();
      chk("rst_valid", bif.bus_valid, 0); chk("rst_stall", stall_m, 0);
      chk("rst_rdata", read_data_m, 0);   chk("rst_addr", bif.bus_addr, 0);
      chk("rst_strb", bif.bus_wstrb, 0);  chk("rst_we", bif.bus_we, 0);
      chk("rst_wdata", bif.bus_wdata, 0);
      chk("rst_mis", misaligned_m, 0);    chk("rst_flt", fault_m, 0);
      rst = 1'b0;

      access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("lw_addr", o_addr, 32'h100); chk("lw_strb", o_strb, 0); chk("lw_we", o_we, 0);
      chk("lw_data", o_rd, 32'hDEADBEEF);
      access(1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("lb_addr", o_addr, 32'h100); chk("lb_data", o_rd, 32'hFFFFFF80);
      access(1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("lbu_data", o_rd, 32'h00000080);
      access(1, 0, 3'b001, 32'h102, 0, 32'h80FF0000, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("lh_data", o_rd, 32'hFFFF80FF);
      access(0, 1, 3'b000, 32'h201, 32'h000000AB, 0, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("sb_addr", o_addr, 32'h200); chk("sb_strb", o_strb, 4'b0010);
      chk("sb_wdata", o_wdata, 32'hABABABAB); chk("sb_we", o_we, 1); chk("sb_rdata", o_rd, 0);
      access(0, 1, 3'b001, 32'h202, 32'hFFFF1234, 0, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("sh_strb", o_strb, 4'b1100); chk("sh_wdata", o_wdata, 32'h12341234); chk("sh_we", o_we, 1);
      access(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("sw_addr", o_addr, 32'h204); chk("sw_strb", o_strb, 4'b1111);
      chk("sw_wdata", o_wdata, 32'hCAFEF00D); chk("sw_we", o_we, 1);
      access(1, 0, 3'b101, 32'h102, 0, 32'h80FF0000, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("lhu_data", o_rd, 32'h000080FF);

      // Misaligned lw: one stall cycle, no bus request, result cleared.
      next();
      mem_read_m = 1; mem_write_m = 0; funct3_m = 3'b010; alu_result_m = 32'h102;
      #1;
      chk("mis_c0_stall", stall_m, 1); chk("mis_c0_valid", bif.bus_valid, 0);
      next();
      chk("mis_c1_stall", stall_m, 0); chk("mis_c1_valid", bif.bus_valid, 0);
      chk("mis_pulse", misaligned_m, 1); chk("mis_flt", fault_m, 0); chk("mis_rdata", read_data_m, 0);
      next();
      mem_read_m = 0;
      #1;
      chk("mis_pulse_end", misaligned_m, 0); chk("mis_idle_stall", stall_m, 0);

      // Illegal funct3 and read+write both give a fault without bus activity.
      mem_read_m = 1; funct3_m = 3'b011; alu_result_m = 32'h300;
      #1;
      chk("ill_c0_stall", stall_m, 1);
      next();
      chk("ill_valid", bif.bus_valid, 0); chk("ill_fault", fault_m, 1); chk("ill_mis", misaligned_m, 0);
      next();
      mem_read_m = 1; mem_write_m = 1; funct3_m = 3'b010;
      #1;
      next();
      chk("rw_valid", bif.bus_valid, 0); chk("rw_fault", fault_m, 1); chk("rw_stall", stall_m, 0);

      // lhu leaves nonzero data so the error path visibly clears it.
      access(1, 0, 3'b101, 32'h102, 0, 32'h80FF0000, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("lhu2_data", o_rd, 32'h000080FF);

      // Delayed ready, then error response: six stall cycles.
      next();
      mem_read_m = 1; mem_write_m = 0; funct3_m = 3'b010; alu_result_m = 32'h300;
      bif.bus_ready = 0; bif.bus_rvalid = 0; bif.bus_rerr = 0;
      stall_cnt = 0;
      #1;
      if (stall_m) stall_cnt++;
      for (int i = 0; i < 3; i++) begin
         next();
         chk("dly_valid", bif.bus_valid, 1); chk("dly_addr", bif.bus_addr, 32'h300);
         if (stall_m) stall_cnt++;
      end
      next();
      bif.bus_ready = 1;
      #1;
      chk("acc_valid", bif.bus_valid, 1); chk("acc_addr", bif.bus_addr, 32'h300);
      if (stall_m) stall_cnt++;
      next();
      bif.bus_ready = 0; bif.bus_rvalid = 1; bif.bus_rerr = 1; bif.bus_rdata = 32'h12345678;
      #1;
      chk("err_resp_valid", bif.bus_valid, 0);
      if (stall_m) stall_cnt++;
      next();
      bif.bus_rvalid = 0; bif.bus_rerr = 0;
      #1;
      chk("err_stall", stall_m, 0); chk("err_fault", fault_m, 1); chk("err_rdata", read_data_m, 0);
      chk("err_stall_cnt", stall_cnt, 6);
      next();
      mem_read_m = 0;
      #1;
      chk("err_fault_end", fault_m, 0);

      // Reset while waiting in RESP; the late response must be dropped.
      mem_read_m = 1; funct3_m = 3'b010; alu_result_m = 32'h400; bif.bus_ready = 1;
      next();
      chk("rr_req", bif.bus_valid, 1);
      next();
      chk("rr_resp_valid", bif.bus_valid, 0); chk("rr_resp_stall", stall_m, 1);
      rst = 1; bif.bus_rvalid = 1; bif.bus_rdata = 32'h11111111;
      next();
      rst = 0; bif.bus_rvalid = 0; mem_read_m = 0;
      #1;
      chk("rr_valid", bif.bus_valid, 0); chk("rr_stall0", stall_m, 0); chk("rr_rdata", read_data_m, 0);
      mem_read_m = 1;
      #1;
      chk("rr_stall1", stall_m, 1);
      mem_read_m = 0;
      #1;
      access(1, 0, 3'b010, 32'h404, 0, 32'h5A5A5A5A, o_addr, o_wdata, o_rd, o_strb, o_we);
      chk("rr_lw_addr", o_addr, 32'h404); chk("rr_lw_data", o_rd, 32'h5A5A5A5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
